// File: rtl/ioshim_mem_arb.sv
// ioshim_mem_arb: round-robin arbiter with bounded lock for the ioshim dual-port memory port 1
//   clk, resetn                  clock, asynchronous active-low reset
//   a_valid/a_ready, a_wen,      requester A (host bus): handshake, byte enables (00 = read),
//   a_addr, a_wdata, a_lock      word address, write data, keep ownership after this transfer
//   a_rvalid, a_rdata            requester A read return, one cycle after a read transfer
//   b_*                          same set for requester B (IO engine)
//   mem_wen, mem_addr, mem_wdata drive to memory wen1/addr1/wdata1
//   mem_rdata                    memory rdata1, registered inside the memory (1-cycle latency)
module ioshim_mem_arb #(
  parameter int ABITS   = 11,
  parameter int MAXHOLD = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             a_valid,
  output logic             a_ready,
  input  logic [1:0]       a_wen,
  input  logic [ABITS-1:0] a_addr,
  input  logic [15:0]      a_wdata,
  input  logic             a_lock,
  output logic             a_rvalid,
  output logic [15:0]      a_rdata,
  input  logic             b_valid,
  output logic             b_ready,
  input  logic [1:0]       b_wen,
  input  logic [ABITS-1:0] b_addr,
  input  logic [15:0]      b_wdata,
  input  logic             b_lock,
  output logic             b_rvalid,
  output logic [15:0]      b_rdata,
  output logic [1:0]       mem_wen,
  output logic [ABITS-1:0] mem_addr,
  output logic [15:0]      mem_wdata,
  input  logic [15:0]      mem_rdata
);
  // A lock taken at cycle t blocks the other side for cycles t+1..t+MAXHOLD-1,
  // so the release fires when the counter sits at MAXHOLD-2.
  localparam bit         LOCK_EN = MAXHOLD > 1;
  localparam logic [7:0] LIM     = MAXHOLD > 1 ? 8'(MAXHOLD - 2) : 8'd0;
  logic       ptr;
  logic       own_a;
  logic       own_b;
  logic       rv_a;
  logic       rv_b;
  logic [7:0] cnt;
  logic       forced;
  always_comb begin
    forced    = (own_a | own_b) && cnt == LIM;
    a_ready   = resetn & a_valid & (own_a | (~own_b & (~b_valid | ~ptr)));
    b_ready   = resetn & b_valid & (own_b | (~own_a & (~a_valid | ptr)));
    mem_wen   = a_ready ? a_wen : b_ready ? b_wen : 2'b00;
    mem_addr  = b_ready ? b_addr : a_addr;
    mem_wdata = b_ready ? b_wdata : a_wdata;
    a_rvalid  = rv_a;
    b_rvalid  = rv_b;
    a_rdata   = mem_rdata;
    b_rdata   = mem_rdata;
  end
  // ptr = 1 prefers B. A forced release hands preference to the non-owner and
  // discards any locked transfer made in the same cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ptr   <= 1'b0;
      own_a <= 1'b0;
      own_b <= 1'b0;
      cnt   <= 8'd0;
      rv_a  <= 1'b0;
      rv_b  <= 1'b0;
    end else begin
      rv_a <= a_ready && a_wen == 2'b00;
      rv_b <= b_ready && b_wen == 2'b00;
      if (forced) begin
        own_a <= 1'b0;
        own_b <= 1'b0;
        cnt   <= 8'd0;
        ptr   <= own_a;
      end else if (a_ready | b_ready) begin
        ptr   <= a_ready;
        own_a <= LOCK_EN & a_ready & a_lock;
        own_b <= LOCK_EN & b_ready & b_lock;
        cnt   <= ((own_a & a_lock) | (own_b & b_lock)) ? cnt + 8'd1 : 8'd0;
      end else if (own_a | own_b) begin
        cnt <= cnt + 8'd1;
      end
    end
  end
endmodule

// File: tb/tb_ioshim_mem_arb.sv
// tb_ioshim_mem_arb: directed self-checking bench for ioshim_mem_arb with a behavioural memory
module tb_ioshim_mem_arb;
  localparam int ABITS = 11;
  logic             clk = 1'b0;
  logic             resetn;
  logic             a_valid, a_ready, a_lock, a_rvalid;
  logic [1:0]       a_wen;
  logic [ABITS-1:0] a_addr;
  logic [15:0]      a_wdata, a_rdata;
  logic             b_valid, b_ready, b_lock, b_rvalid;
  logic [1:0]       b_wen;
  logic [ABITS-1:0] b_addr;
  logic [15:0]      b_wdata, b_rdata;
  logic [1:0]       mem_wen;
  logic [ABITS-1:0] mem_addr;
  logic [15:0]      mem_wdata, mem_rdata;
  logic [15:0]      mem [0:(1<<ABITS)-1];
  int total = 0;
  int bad = 0;

  ioshim_mem_arb #(.ABITS(ABITS), .MAXHOLD(8)) dut (
    .clk(clk), .resetn(resetn),
    .a_valid(a_valid), .a_ready(a_ready), .a_wen(a_wen), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_lock(a_lock), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
    .b_valid(b_valid), .b_ready(b_ready), .b_wen(b_wen), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_lock(b_lock), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_wen[0]) mem[mem_addr][7:0] <= mem_wdata[7:0];
    if (mem_wen[1]) mem[mem_addr][15:8] <= mem_wdata[15:8];
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    a_valid = 0; a_lock = 0; a_wen = 2'b00; a_addr = '0; a_wdata = '0;
    b_valid = 0; b_lock = 0; b_wen = 2'b00; b_addr = '0; b_wdata = '0;
  endtask

  initial begin
    idle();
    resetn = 0;
    a_valid = 1; b_valid = 1;
    #1;
    @(negedge clk);
    chk("reset_outputs", {27'd0, a_ready, b_ready, mem_wen, a_rvalid}, 32'd0);
    chk("reset_b_rvalid", {31'd0, b_rvalid}, 32'd0);
    tick();
    idle();
    resetn = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_quiet", {26'd0, a_ready, b_ready, mem_wen, a_rvalid, b_rvalid}, 32'd0);
      tick();
    end
    a_valid = 1; a_wen = 2'b11; a_addr = 11'h005; a_wdata = 16'h1234;
    @(negedge clk);
    chk("preload_w5", {a_ready, b_ready, mem_wen, 5'd0, mem_addr, mem_wdata}, {1'b1, 1'b0, 2'b11, 5'd0, 11'h005, 16'h1234});
    tick();
    a_addr = 11'h007; a_wdata = 16'h1111;
    @(negedge clk);
    chk("preload_w7", {a_ready, mem_wen, 5'd0, mem_addr}, {1'b1, 2'b11, 5'd0, 11'h007});
    tick();
    a_wen = 2'b00; a_addr = 11'h005;
    @(negedge clk);
    chk("a_read_ready", {a_ready, b_ready, mem_wen}, 4'b1000);
    tick();
    idle();
    @(negedge clk);
    chk("a_read_ret", {a_rvalid, b_rvalid, a_rdata}, {2'b10, 16'h1234});
    tick();
    a_valid = 1; a_wen = 2'b10; a_addr = 11'h007; a_wdata = 16'hABCD;
    @(negedge clk);
    chk("a_bytewrite", {a_ready, mem_wen, mem_wdata}, {1'b1, 2'b10, 16'hABCD});
    tick();
    idle();
    b_valid = 1; b_addr = 11'h007;
    @(negedge clk);
    chk("b_read_ready", {a_ready, b_ready, a_rvalid, mem_wen}, 5'b01000);
    tick();
    idle();
    @(negedge clk);
    chk("b_read_ret", {a_rvalid, b_rvalid, b_rdata}, {2'b01, 16'hAB11});
    tick();
    resetn = 0;
    tick();
    resetn = 1;
    a_valid = 1; a_addr = 11'h005; b_valid = 1; b_addr = 11'h007;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_grant", {30'd0, a_ready, b_ready}, (i % 2 == 0) ? 32'd2 : 32'd1);
      chk("rr_rvalid", {30'd0, a_rvalid, b_rvalid}, (i == 0) ? 32'd0 : (i % 2 == 1) ? 32'd2 : 32'd1);
      if (i == 1) chk("rr_a_rdata", {16'd0, a_rdata}, 32'h1234);
      tick();
    end
    idle();
    @(negedge clk);
    chk("rr_last_ret", {a_rvalid, b_rvalid, b_rdata}, {2'b01, 16'hAB11});
    tick();
    a_valid = 1; a_lock = 1; a_wen = 2'b11; a_addr = 11'h010; a_wdata = 16'h5555; b_valid = 1; b_addr = 11'h007;
    @(negedge clk);
    chk("lock_take", {30'd0, a_ready, b_ready}, 32'd2);
    tick();
    a_valid = 0; a_lock = 0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk("lock_block_b", {30'd0, a_ready, b_ready}, 32'd0);
      tick();
    end
    @(negedge clk);
    chk("lock_forced_rel", {30'd0, a_ready, b_ready}, 32'd1);
    tick();
    a_valid = 1; a_lock = 1;
    @(negedge clk);
    chk("lock2_take", {30'd0, a_ready, b_ready}, 32'd2);
    tick();
    a_lock = 0;
    @(negedge clk);
    chk("lock2_owner_wins", {30'd0, a_ready, b_ready}, 32'd2);
    tick();
    @(negedge clk);
    chk("lock2_released", {30'd0, a_ready, b_ready}, 32'd1);
    tick();
    idle();
    tick();
    a_valid = 1; a_lock = 1; a_wen = 2'b00; a_addr = 11'h005;
    @(negedge clk);
    chk("rst_lock_read", {30'd0, a_ready, b_ready}, 32'd2);
    tick();
    resetn = 0;
    idle();
    @(negedge clk);
    chk("rst_drop_rvalid", {29'd0, a_rvalid, b_rvalid, a_ready}, 32'd0);
    tick();
    resetn = 1;
    @(negedge clk);
    chk("rst_still_quiet", {30'd0, a_rvalid, b_rvalid}, 32'd0);
    tick();
    a_valid = 1; b_valid = 1; a_addr = 11'h005; b_addr = 11'h007;
    @(negedge clk);
    chk("rst_contention_a", {30'd0, a_ready, b_ready}, 32'd2);
    tick();
    idle();
    tick();
    a_valid = 1; a_lock = 1; a_wen = 2'b11; a_addr = 11'h020; a_wdata = 16'h0F0F;
    @(negedge clk);
    chk("rst2_lock_take", {31'd0, a_ready}, 32'd1);
    tick();
    resetn = 0;
    idle();
    tick();
    resetn = 1;
    b_valid = 1; b_addr = 11'h020;
    @(negedge clk);
    chk("rst2_lock_cleared", {30'd0, a_ready, b_ready}, 32'd1);
    tick();
    idle();
    @(negedge clk);
    chk("rst2_b_ret", {b_rvalid, b_rdata}, {1'b1, 16'h0F0F});
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
